// File: rtl/audio_stream_mixer.sv
// audio_stream_mixer: two-input stereo gain/sum/saturate mixer.
// 3-stage AXI4-Stream pipeline with A/B join and beat/clip counters.
module audio_stream_mixer #(
  parameter int SAMPLE_W = 24,
  parameter int GAIN_W   = 16
) (
  input  logic              axis_aclk,
  input  logic              axis_aresetn,
  input  logic              s_a_axis_tvalid,
  output logic              s_a_axis_tready,
  input  logic [63:0]       s_a_axis_tdata,
  input  logic              s_b_axis_tvalid,
  output logic              s_b_axis_tready,
  input  logic [63:0]       s_b_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [63:0]       m_axis_tdata,
  input  logic              b_enable,
  input  logic [GAIN_W-1:0] gain_a_l,
  input  logic [GAIN_W-1:0] gain_a_r,
  input  logic [GAIN_W-1:0] gain_b_l,
  input  logic [GAIN_W-1:0] gain_b_r,
  output logic [31:0]       frame_count,
  output logic [31:0]       sat_count
);

  localparam int PW   = SAMPLE_W + GAIN_W + 1;
  localparam int QW   = SAMPLE_W + 2;
  localparam int SUMW = QW + 1;
  localparam int EXTW = 32 - SAMPLE_W;

  localparam logic signed [SUMW-1:0] SAT_MAX =
    {{(SUMW-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SUMW-1:0] SAT_MIN = ~SAT_MAX;

  // x * {0,gain} >>> (GAIN_W-1); |q| < 2^SAMPLE_W so QW bits never wrap
  function automatic logic signed [QW-1:0] scale(
    input logic [SAMPLE_W-1:0] x,
    input logic [GAIN_W-1:0]   g
  );
    logic signed [PW-1:0] xs;
    logic signed [PW-1:0] gs;
    logic signed [PW-1:0] p;
    xs = PW'($signed(x));
    gs = PW'({1'b0, g});
    p  = xs * gs;
    return QW'(p >>> (GAIN_W - 1));
  endfunction

  // returns {clip, lane}
  function automatic logic [SAMPLE_W:0] clamp(
    input logic signed [SUMW-1:0] s
  );
    logic [SAMPLE_W:0] r;
    unique case (1'b1)
      (s > SAT_MAX): r = {1'b1, SAT_MAX[SAMPLE_W-1:0]};
      (s < SAT_MIN): r = {1'b1, SAT_MIN[SAMPLE_W-1:0]};
      default:       r = {1'b0, s[SAMPLE_W-1:0]};
    endcase
    return r;
  endfunction

  logic adv;
  logic a_fire;
  logic m_fire;

  logic [SAMPLE_W-1:0] a_l;
  logic [SAMPLE_W-1:0] a_r;
  logic [SAMPLE_W-1:0] b_l;
  logic [SAMPLE_W-1:0] b_r;

  logic [SAMPLE_W:0] sat_l;
  logic [SAMPLE_W:0] sat_r;

  logic                 s1_v_q, s1_v_d;
  logic signed [QW-1:0] qa_l_q, qa_l_d;
  logic signed [QW-1:0] qa_r_q, qa_r_d;
  logic signed [QW-1:0] qb_l_q, qb_l_d;
  logic signed [QW-1:0] qb_r_q, qb_r_d;

  logic                   s2_v_q, s2_v_d;
  logic signed [SUMW-1:0] sum_l_q, sum_l_d;
  logic signed [SUMW-1:0] sum_r_q, sum_r_d;

  logic                s3_v_q, s3_v_d;
  logic [SAMPLE_W-1:0] out_l_q, out_l_d;
  logic [SAMPLE_W-1:0] out_r_q, out_r_d;
  logic                clip_q, clip_d;

  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] sat_cnt_q, sat_cnt_d;

  logic unused_hi;

  assign a_l = s_a_axis_tdata[32 +: SAMPLE_W];
  assign a_r = s_a_axis_tdata[0 +: SAMPLE_W];
  assign b_l = s_b_axis_tdata[32 +: SAMPLE_W];
  assign b_r = s_b_axis_tdata[0 +: SAMPLE_W];

  assign unused_hi = ^{s_a_axis_tdata[63:32+SAMPLE_W],
                       s_a_axis_tdata[31:SAMPLE_W],
                       s_b_axis_tdata[63:32+SAMPLE_W],
                       s_b_axis_tdata[31:SAMPLE_W]};

  // whole pipeline moves as one; A and B join so neither is taken alone
  assign adv = !s3_v_q | m_axis_tready;

  assign s_a_axis_tready = axis_aresetn & adv &
                           (b_enable ? s_b_axis_tvalid : 1'b1);
  assign s_b_axis_tready = axis_aresetn & adv &
                           b_enable & s_a_axis_tvalid;

  assign a_fire = s_a_axis_tvalid & s_a_axis_tready;
  assign m_fire = s3_v_q & m_axis_tready;

  // next-state for the three pipeline stages and the counters
  always_comb begin
    s1_v_d      = s1_v_q;
    qa_l_d      = qa_l_q;
    qa_r_d      = qa_r_q;
    qb_l_d      = qb_l_q;
    qb_r_d      = qb_r_q;
    s2_v_d      = s2_v_q;
    sum_l_d     = sum_l_q;
    sum_r_d     = sum_r_q;
    s3_v_d      = s3_v_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    clip_d      = clip_q;
    frame_cnt_d = frame_cnt_q;
    sat_cnt_d   = sat_cnt_q;
    sat_l       = clamp(sum_l_q);
    sat_r       = clamp(sum_r_q);

    if (adv) begin
      s1_v_d  = a_fire;
      qa_l_d  = scale(a_l, gain_a_l);
      qa_r_d  = scale(a_r, gain_a_r);
      qb_l_d  = b_enable ? scale(b_l, gain_b_l) : '0;
      qb_r_d  = b_enable ? scale(b_r, gain_b_r) : '0;

      s2_v_d  = s1_v_q;
      sum_l_d = SUMW'(qa_l_q) + SUMW'(qb_l_q);
      sum_r_d = SUMW'(qa_r_q) + SUMW'(qb_r_q);

      s3_v_d  = s2_v_q;
      out_l_d = sat_l[SAMPLE_W-1:0];
      out_r_d = sat_r[SAMPLE_W-1:0];
      clip_d  = sat_l[SAMPLE_W] | sat_r[SAMPLE_W];
    end

    if (m_fire) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
      if (clip_q && (sat_cnt_q != '1)) begin
        sat_cnt_d = sat_cnt_q + 32'd1;
      end
    end
  end

  // state registers; reset drops every in-flight beat
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      s1_v_q      <= 1'b0;
      qa_l_q      <= '0;
      qa_r_q      <= '0;
      qb_l_q      <= '0;
      qb_r_q      <= '0;
      s2_v_q      <= 1'b0;
      sum_l_q     <= '0;
      sum_r_q     <= '0;
      s3_v_q      <= 1'b0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      clip_q      <= 1'b0;
      frame_cnt_q <= '0;
      sat_cnt_q   <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      qa_l_q      <= qa_l_d;
      qa_r_q      <= qa_r_d;
      qb_l_q      <= qb_l_d;
      qb_r_q      <= qb_r_d;
      s2_v_q      <= s2_v_d;
      sum_l_q     <= sum_l_d;
      sum_r_q     <= sum_r_d;
      s3_v_q      <= s3_v_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      clip_q      <= clip_d;
      frame_cnt_q <= frame_cnt_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign m_axis_tvalid = s3_v_q;
  assign m_axis_tdata  = {{EXTW{out_l_q[SAMPLE_W-1]}}, out_l_q,
                          {EXTW{out_r_q[SAMPLE_W-1]}}, out_r_q};
  assign frame_count   = frame_cnt_q;
  assign sat_count     = sat_cnt_q;

endmodule

// File: tb/tb_audio_stream_mixer.sv
// tb_audio_stream_mixer: vector table, join/stall/reset sequences,
// and a scoreboard fed by an arithmetic reference of the mixer.
module tb_audio_stream_mixer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [63:0] a_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [63:0] b_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_data;
  logic        b_en = 1'b0;
  logic [15:0] ga_l = '0;
  logic [15:0] ga_r = '0;
  logic [15:0] gb_l = '0;
  logic [15:0] gb_r = '0;
  logic [31:0] frame_count;
  logic [31:0] sat_count;

  always #5 clk = ~clk;

  audio_stream_mixer #(.SAMPLE_W(24), .GAIN_W(16)) dut (
    .axis_aclk       (clk),
    .axis_aresetn    (rst_n),
    .s_a_axis_tvalid (a_valid),
    .s_a_axis_tready (a_ready),
    .s_a_axis_tdata  (a_data),
    .s_b_axis_tvalid (b_valid),
    .s_b_axis_tready (b_ready),
    .s_b_axis_tdata  (b_data),
    .m_axis_tvalid   (m_valid),
    .m_axis_tready   (m_ready),
    .m_axis_tdata    (m_data),
    .b_enable        (b_en),
    .gain_a_l        (ga_l),
    .gain_a_r        (ga_r),
    .gain_b_l        (gb_l),
    .gain_b_r        (gb_r),
    .frame_count     (frame_count),
    .sat_count       (sat_count)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    logic        clip;
  } exp_t;

  typedef struct {
    logic        en;
    logic [15:0] ga_l;
    logic [15:0] ga_r;
    logic [15:0] gb_l;
    logic [15:0] gb_r;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_data;
    logic [31:0] exp_frames;
    logic [31:0] exp_sat;
  } vec_t;

  vec_t vecs[10];
  exp_t sb[$];
  logic [31:0] exp_frames = '0;
  logic [31:0] exp_sat = '0;
  logic        hold_v = 1'b0;
  logic [63:0] hold_d = '0;
  logic        mon_adv;
  exp_t        mon_e;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic longint sx24(input logic [31:0] lane);
    longint v;
    v = longint'(lane[23:0]);
    if (lane[23]) v = v - 64'sd16777216;
    return v;
  endfunction

  function automatic longint fdiv(input longint p);
    longint q;
    q = p / 32768;
    if ((p % 32768) != 0 && p < 0) q = q - 1;
    return q;
  endfunction

  // {clip, 32-bit lane}
  function automatic logic [32:0] mix_lane(
    input logic [31:0] a, input logic [15:0] ga,
    input logic [31:0] b, input logic [15:0] gb, input logic en);
    longint s;
    logic   c;
    s = fdiv(sx24(a) * longint'(ga));
    if (en) s = s + fdiv(sx24(b) * longint'(gb));
    c = 1'b0;
    if (s > 64'sd8388607) begin
      s = 64'sd8388607;
      c = 1'b1;
    end else if (s < -64'sd8388608) begin
      s = -64'sd8388608;
      c = 1'b1;
    end
    return {c, s[31:0]};
  endfunction

  function automatic exp_t ref_beat(
    input logic [63:0] a, input logic [63:0] b,
    input logic [15:0] gal, input logic [15:0] gar,
    input logic [15:0] gbl, input logic [15:0] gbr, input logic en);
    logic [32:0] l;
    logic [32:0] r;
    exp_t e;
    l = mix_lane(a[63:32], gal, b[63:32], gbl, en);
    r = mix_lane(a[31:0], gar, b[31:0], gbr, en);
    e.data = {l[31:0], r[31:0]};
    e.clip = l[32] | r[32];
    return e;
  endfunction

  // protocol, hold, counter and scoreboard checks each cycle
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      hold_v = 1'b0;
    end else begin
      check("frame_count", frame_count, exp_frames);
      check("sat_count", sat_count, exp_sat);
      mon_adv = !m_valid | m_ready;
      check("a_ready", a_ready, b_en ? (mon_adv & b_valid) : mon_adv);
      check("b_ready", b_ready, b_en ? (mon_adv & a_valid) : 1'b0);
      if (hold_v) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", m_data, hold_d);
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      if (a_valid && a_ready) begin
        sb.push_back(ref_beat(a_data, b_data, ga_l, ga_r, gb_l, gb_r, b_en));
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", m_data, 64'hx);
        end else begin
          mon_e = sb.pop_front();
          check("mix_data", m_data, mon_e.data);
          exp_frames = exp_frames + 32'd1;
          if (mon_e.clip && exp_sat != 32'hFFFF_FFFF)
            exp_sat = exp_sat + 32'd1;
        end
      end
    end
  end

  task automatic apply_vec(input int idx, input vec_t v);
    int n;
    int lat;
    b_en = v.en;
    ga_l = v.ga_l; ga_r = v.ga_r;
    gb_l = v.gb_l; gb_r = v.gb_r;
    a_data = v.a; b_data = v.b;
    a_valid = 1'b1; b_valid = 1'b1; m_ready = 1'b1;
    #1;
    n = 0;
    while (!a_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check($sformatf("vec%0d_accept", idx), a_ready, 1'b1);
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    lat = 1;
    while (!m_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check($sformatf("vec%0d_latency", idx), lat, 3);
    check($sformatf("vec%0d_data", idx), m_data, v.exp_data);
    @(posedge clk); #1;
    check($sformatf("vec%0d_frames", idx), frame_count, v.exp_frames);
    check($sformatf("vec%0d_sat", idx), sat_count, v.exp_sat);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || m_valid) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("drain_queue", sb.size(), 0);
    check("drain_valid", m_valid, 1'b0);
  endtask

  task automatic test_join();
    logic [63:0] ad[8];
    logic [63:0] bd[8];
    logic [31:0] f0;
    int ia;
    int ib;
    bit fa;
    bit fb;
    for (int i = 0; i < 8; i++) begin
      ad[i] = {$urandom, $urandom};
      bd[i] = {$urandom, $urandom};
    end
    f0 = exp_frames;
    ia = 0; ib = 0;
    b_en = 1'b1; m_ready = 1'b1;
    ga_l = 16'($urandom); ga_r = 16'($urandom);
    gb_l = 16'($urandom); gb_r = 16'($urandom);
    for (int c = 0; c < 200 && (ia < 8 || ib < 8); c++) begin
      a_valid = (ia < 8);
      a_data = ad[ia % 8];
      b_valid = (c % 4 == 0) && (ib < 8);
      b_data = bd[ib % 8];
      #1;
      fa = a_valid && a_ready;
      fb = b_valid && b_ready;
      @(posedge clk); #1;
      if (fa) ia++;
      if (fb) ib++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check("join_a_count", ia, 8);
    check("join_b_count", ib, 8);
    drain();
    check("join_frames", frame_count, f0 + 32'd8);
  endtask

  task automatic test_stream();
    logic [31:0] f0;
    int k;
    int cur;
    bit fa;
    f0 = exp_frames;
    k = 0; cur = -1;
    for (int c = 0; c < 3000 && k < 32; c++) begin
      if (cur != k) begin
        cur = k;
        b_en = 1'($urandom_range(0, 1));
        ga_l = 16'($urandom); ga_r = 16'($urandom);
        gb_l = 16'($urandom); gb_r = 16'($urandom);
        a_data = {$urandom, $urandom};
        b_data = {$urandom, $urandom};
      end
      m_ready = 1'($urandom_range(0, 1));
      a_valid = 1'b1;
      b_valid = ($urandom_range(0, 3) != 0);
      #1;
      fa = a_valid && a_ready;
      @(posedge clk); #1;
      if (fa) k++;
    end
    a_valid = 1'b0; b_valid = 1'b0; m_ready = 1'b1;
    check("stream_beats", k, 32);
    drain();
    check("stream_frames", frame_count, f0 + 32'd32);
  endtask

  task automatic test_reset();
    int k;
    bit fa;
    b_en = 1'b0; m_ready = 1'b0;
    ga_l = 16'h8000; ga_r = 16'h8000;
    k = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      a_valid = 1'b1;
      a_data = {32'd100 + 32'(k), 32'd7};
      #1;
      fa = a_valid && a_ready;
      @(posedge clk); #1;
      if (fa) k++;
    end
    check("rst_fill", k, 3);
    check("rst_pre_valid", m_valid, 1'b1);
    rst_n = 1'b0;
    sb.delete();
    exp_frames = '0;
    exp_sat = '0;
    #1;
    check("rst_valid", m_valid, 1'b0);
    check("rst_data", m_data, 64'h0);
    check("rst_frames", frame_count, 32'h0);
    check("rst_sat", sat_count, 32'h0);
    check("rst_a_ready", a_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a_valid = 1'b0;
    m_ready = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("rst_no_stale", m_valid, 1'b0);
    end
    apply_vec(10, vecs[0]);
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                64'h00000100_FFFFFF00, 64'h0,
                64'h00000100_FFFFFF00, 32'd1, 32'd0};
    vecs[1] = '{1'b1, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                64'h00400000_00000000, 64'h00400000_00000000,
                64'h007FFFFF_00000000, 32'd2, 32'd1};
    vecs[2] = '{1'b1, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                64'h00C00000_00000000, 64'h00BFFFFF_00000000,
                64'hFF800000_00000000, 32'd3, 32'd2};
    vecs[3] = '{1'b0, 16'h4000, 16'h4000, 16'h8000, 16'h8000,
                64'h00000003_00FFFFFD, 64'h0,
                64'h00000001_FFFFFFFE, 32'd4, 32'd2};
    vecs[4] = '{1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                64'hAB000010_FF7FFFFF, 64'h0,
                64'h00000010_007FFFFF, 32'd5, 32'd2};
    vecs[5] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000,
                64'h007FFFFF_00800000, 64'h0,
                64'h007FFFFF_FF800000, 32'd6, 32'd3};
    vecs[6] = '{1'b1, 16'h8000, 16'h8000, 16'h4000, 16'h8000,
                64'h00000100_00FFFF00, 64'h00000200_00000100,
                64'h00000200_00000000, 32'd7, 32'd3};
    vecs[7] = '{1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                64'h00000010_00000020, 64'h00400000_00400000,
                64'h00000010_00000020, 32'd8, 32'd3};
    vecs[8] = '{1'b0, 16'h0000, 16'h0000, 16'h8000, 16'h8000,
                64'h007FFFFF_00800000, 64'h0,
                64'h00000000_00000000, 32'd9, 32'd3};
    vecs[9] = '{1'b1, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                64'h00C00000_003FFFFF, 64'h00C00000_00400000,
                64'hFF800000_007FFFFF, 32'd10, 32'd3};

    rst_n = 1'b0;
    b_en = 1'b1; a_valid = 1'b1; b_valid = 1'b1; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_m_valid", m_valid, 1'b0);
    check("reset_m_data", m_data, 64'h0);
    check("reset_a_ready", a_ready, 1'b0);
    check("reset_b_ready", b_ready, 1'b0);
    check("reset_frames", frame_count, 32'h0);
    check("reset_sat", sat_count, 32'h0);
    a_valid = 1'b0; b_valid = 1'b0; b_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) apply_vec(i, vecs[i]);

    test_join();
    test_stream();
    test_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
